// File: rtl/ll_module.sv
// Line-length feature extractor: sums |x[n] - x[n-1]| over non-overlapping
// windows of accepted samples and pulses data_valid with each window total.
module ll_module #(
  parameter int DATA_WIDTH   = 16,
  parameter int MID_WIDTH    = 22,
  parameter int OUTPUT_WIDTH = 25,
  parameter int WINDOW       = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic signed [DATA_WIDTH-1:0]   din,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           data_valid
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam int SUM_W = ((MID_WIDTH > OUTPUT_WIDTH) ? MID_WIDTH : OUTPUT_WIDTH) + 1;
  localparam logic [OUTPUT_WIDTH-1:0] ACC_SAT = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};

  logic [DATA_WIDTH-1:0]   prev_q;
  logic                    first_q;
  logic [MID_WIDTH-1:0]    absd_q;
  logic                    s1Valid_q;
  logic [OUTPUT_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [OUTPUT_WIDTH-1:0] dout_q;
  logic                    dataValid_q;

  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0]        negDiff;
  logic [DATA_WIDTH:0]        absDiff;
  logic [MID_WIDTH-1:0]       absd_d;
  logic [SUM_W-1:0]           sumWide;
  logic [OUTPUT_WIDTH-1:0]    acc_d;

  // Difference is one bit wider than the samples so full-scale swings never overflow.
  always_comb begin
    diff    = {din[DATA_WIDTH-1], din} - {prev_q[DATA_WIDTH-1], prev_q};
    negDiff = -diff;
    absDiff = diff[DATA_WIDTH] ? negDiff : diff;
    absd_d  = first_q ? '0 : MID_WIDTH'(absDiff);
  end

  // The accumulator never goes negative, so clamping at the positive limit prevents wrap.
  always_comb begin
    sumWide = SUM_W'(acc_q) + SUM_W'(absd_q);
    acc_d   = (sumWide > SUM_W'(ACC_SAT)) ? ACC_SAT : sumWide[OUTPUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= '0;
      first_q     <= 1'b1;
      absd_q      <= '0;
      s1Valid_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      dataValid_q <= 1'b0;
    end else begin
      s1Valid_q   <= en;
      dataValid_q <= 1'b0;
      if (en) begin
        prev_q  <= din;
        first_q <= 1'b0;
        absd_q  <= absd_d;
      end
      // prev is deliberately not cleared at window end: the boundary difference belongs to the next window.
      if (s1Valid_q) begin
        if (cnt_q == CNT_W'(WINDOW - 1)) begin
          dout_q      <= acc_d;
          dataValid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign data_valid = dataValid_q;

endmodule

// File: tb/tb_ll_module.sv
// Self-checking bench for ll_module: directed patterns plus randomized samples,
// compared against a window-sum reference model.
module tb_ll_module;

  localparam int  DW  = 16;
  localparam int  MW  = 22;
  localparam int  OW  = 25;
  localparam int  WIN = 256;
  localparam longint SAT = (longint'(1) << (OW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic signed [DW-1:0] din;
  logic signed [OW-1:0] dout;
  logic                 data_valid;

  int checksDone   = 0;
  int checksFailed = 0;

  longint expQ[$];
  longint pulseLog[$];
  longint pulseCycles[$];
  longint curDout = 0;
  longint modelPrev = 0;
  bit     modelFirst = 1'b1;
  longint modelSum = 0;
  int     modelCnt = 0;
  longint cycleNo = 0;
  bit     monitorOn = 1'b0;

  ll_module #(
    .DATA_WIDTH(DW), .MID_WIDTH(MW), .OUTPUT_WIDTH(OW), .WINDOW(WIN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dout(dout), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checksDone++;
    if (observed !== expected) begin
      checksFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: each window total is the saturated sum of absolute sample differences.
  task automatic modelAccept(input longint x);
    longint a;
    a = modelFirst ? 0 : ((x > modelPrev) ? (x - modelPrev) : (modelPrev - x));
    modelFirst = 1'b0;
    modelPrev  = x;
    modelSum   = modelSum + a;
    if (modelSum > SAT) modelSum = SAT;
    modelCnt++;
    if (modelCnt == WIN) begin
      expQ.push_back(modelSum);
      modelSum = 0;
      modelCnt = 0;
    end
  endtask

  task automatic modelReset();
    modelFirst = 1'b1;
    modelPrev  = 0;
    modelSum   = 0;
    modelCnt   = 0;
    curDout    = 0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input bit e, input int d);
    en  = e;
    din = d[DW-1:0];
    @(posedge clk);
    #1;
    if (e) modelAccept(longint'(din));
  endtask

  // Asserts reset between clock edges and confirms the outputs clear without waiting for a clock.
  task automatic resetDut(input string tag);
    #2;
    en  = 1'b0;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput({tag, "_dout"}, longint'(dout), 0);
    checkOutput({tag, "_valid"}, longint'(data_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
  endtask

  task automatic checkPulses(input string tag, input longint e0, input longint e1, input longint gap);
    checkOutput({tag, "_npulses"}, longint'(pulseLog.size()), 2);
    if (pulseLog.size() >= 2) begin
      checkOutput({tag, "_w1"}, pulseLog[0], e0);
      checkOutput({tag, "_w2"}, pulseLog[1], e1);
      if (gap > 0) checkOutput({tag, "_gap"}, pulseCycles[1] - pulseCycles[0], gap);
    end
    checkOutput({tag, "_pending"}, longint'(expQ.size()), 0);
  endtask

  // Each data_valid sample consumes one expected window; dout must hold between pulses.
  always @(negedge clk) begin
    cycleNo++;
    if (monitorOn) begin
      if (data_valid) begin
        if (expQ.size() == 0) checkOutput("unexpected_pulse", 1, 0);
        else curDout = expQ.pop_front();
        pulseLog.push_back(longint'(dout));
        pulseCycles.push_back(cycleNo);
      end
      checkOutput("dout", longint'(dout), curDout);
    end
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("por_dout", longint'(dout), 0);
    checkOutput("por_valid", longint'(data_valid), 0);
    rst = 1'b1;
    monitorOn = 1'b1;

    pulseLog.delete(); pulseCycles.delete();
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(1'b1, 1234);
    idleCycles(4);
    checkPulses("const", 0, 0, WIN);

    resetDut("rst_ramp");
    pulseLog.delete(); pulseCycles.delete();
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(1'b1, i);
    idleCycles(4);
    checkPulses("ramp", 255, 256, WIN);

    resetDut("rst_alt");
    pulseLog.delete(); pulseCycles.delete();
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(1'b1, (i % 2 == 0) ? 100 : -100);
    idleCycles(4);
    checkPulses("alt100", 51000, 51200, WIN);

    resetDut("rst_full");
    pulseLog.delete(); pulseCycles.delete();
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(1'b1, (i % 2 == 0) ? 32767 : -32768);
    idleCycles(4);
    checkPulses("fullscale", 16711425, 16776960, WIN);

    resetDut("rst_sparse");
    pulseLog.delete(); pulseCycles.delete();
    for (int k = 0; k < 6 * WIN; k++) begin
      if (k % 3 == 0) applyStimulus(1'b1, k / 3);
      else            applyStimulus(1'b0, int'($urandom));
    end
    idleCycles(4);
    checkPulses("sparse", 255, 256, 3 * WIN);

    // Mid-window reset while dout still holds the previous window's total.
    pulseLog.delete(); pulseCycles.delete();
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, (i % 2 == 0) ? 100 : -100);
    checkOutput("pre_reset_dout", longint'(dout), 256);
    resetDut("midwin");
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(1'b1, (i % 2 == 0) ? 100 : -100);
    idleCycles(4);
    checkPulses("after_reset", 51000, 51200, WIN);

    resetDut("rst_rand");
    pulseLog.delete(); pulseCycles.delete();
    for (int i = 0; i < 1500; i++) applyStimulus(($urandom % 4) != 0, int'($urandom));
    idleCycles(4);
    checkOutput("rand_pending", longint'(expQ.size()), 0);

    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checksDone, checksFailed);
    $finish;
  end

endmodule

// File: doc/ll_module.md
Name: ll_module

Overview:
- Line-length feature extractor for the iEEG seizure-detection datapath.
- Accepts one signed sample per enabled clock and accumulates |x[n] − x[n−1]| over a non-overlapping window of WINDOW accepted samples.
- At the end of each window it presents the sum on dout with a one-cycle data_valid pulse.
- Output feeds the downstream threshold/classifier stage.

Parameters:
- DATA_WIDTH, 16, width of signed input sample din.
- MID_WIDTH, 22, width of the registered unsigned absolute-difference stage; must be ≥ DATA_WIDTH+1.
- OUTPUT_WIDTH, 25, width of signed accumulator and dout.
- WINDOW, 256, accepted samples per window; power of two, ≥ 2.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, sample-valid qualifier; din is accepted on a rising edge when en=1.
- din, input, DATA_WIDTH signed, iEEG sample.
- dout, output, OUTPUT_WIDTH signed, line-length of the last completed window; always ≥ 0.
- data_valid, output, 1, one-cycle pulse when dout is updated.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous):
  - Clears dout, data_valid, accumulator, sample counter, previous-sample register, stage-1 register and stage-1 valid flag.
  - Sets first-sample flag.
  - Takes effect immediately, mid-window included; the partial window is discarded.
- en=0: no sample accepted; counter, accumulator and previous sample hold. data_valid=0 except for a pulse already in flight from a sample accepted earlier.
- Stage 1, on an edge with en=1:
  - diff = din − prev, computed at DATA_WIDTH+1 bits signed.
  - absd = |diff|, zero-extended to MID_WIDTH; absd is 0 if the first-sample flag is set.
  - prev <= din; first-sample flag cleared; stage-1 valid set for one cycle.
- Stage 2, on the next edge with stage-1 valid:
  - acc_next = acc + absd.
  - Counter increments; when counter was WINDOW−1: dout <= acc_next, data_valid <= 1, acc <= 0, counter <= 0.
  - Otherwise acc <= acc_next.
- Latency: data_valid is high in the cycle after the second rising edge following acceptance of the WINDOW-th sample.
- data_valid is exactly one cycle wide. dout holds its value between pulses.
- prev carries across window boundaries: the difference between the last sample of window k and the first of window k+1 counts in window k+1. Only the very first window after reset has a zero first term.
- Accumulator saturates at 2^(OUTPUT_WIDTH−1)−1; it never wraps. With defaults the maximum 256×65535 = 16,776,960 fits without saturation.
- Back-to-back en=1 every cycle is supported at full throughput; stage 2 never stalls.
- en toggling arbitrarily is allowed; windows count accepted samples only.

Test Plan:
- Reset then din constant 1234, en=1 for 512 cycles → two data_valid pulses, dout=0 each; dout=0 and data_valid=0 during and after reset.
- Ramp din=0,1,2,… with en=1 → first window dout=255, second window dout=256.
- Alternating +100/−100 with en=1 → first dout=51000, second dout=51200; pulses exactly 256 accepted samples apart, each 1 cycle wide.
- Alternating 32767/−32768 → first dout=16,711,425, then 16,776,960; no wrap, dout stays positive.
- Ramp with en=1 only every third cycle → same dout values as the ramp case; data_valid pulse spacing 768 cycles; state holds when en=0.
- Assert rst=0 asynchronously (between clock edges) after 100 samples of the alternating ±100 pattern, release, restart the same pattern → outputs clear immediately; next dout=51000 after 256 new samples.
